// File: rtl/spi_master.sv
// spi_master: mode-0, MSB-first SPI master for the register-access slave
// protocol (ID byte, address byte, data byte). Writes shift the data byte
// out on mosi. Reads capture the third byte from miso into rdata.
// Optional build macro: SPI_MASTER_MISO_SYNC_EN routes miso through a
// 2-flop synchronizer and moves the sample point 2 clocks after each sclk rise.
module spi_master #(
    parameter int unsigned CLK_DIV   = 8,
    parameter int unsigned SS_GAP    = 8,
    parameter logic [7:0]  SLAVE_IDW = 8'hFF,
    parameter logic [7:0]  SLAVE_IDR = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned BIT_W   = 5;
    localparam int unsigned SHIFT_W = 24;
    localparam int unsigned BYTE_W  = 8;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(SS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(SHIFT_W - 1);
    localparam logic [BIT_W-1:0] RX_FIRST  = BIT_W'(SHIFT_W - BYTE_W);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]         state;
    logic [2:0]         state_d;
    logic [CNT_W-1:0]   half_cnt;
    logic [CNT_W-1:0]   half_d;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_d;
    logic [SHIFT_W-1:0] sreg;
    logic [SHIFT_W-1:0] sreg_d;
    logic [BYTE_W-1:0]  rx;
    logic [BYTE_W-1:0]  rx_d;
    logic               rw_q;
    logic               rw_d;
    logic               busy_d;
    logic               done_d;
    logic [BYTE_W-1:0]  rdata_d;
    logic               ss_d;
    logic               sclk_d;
    logic               mosi_d;
    logic [BYTE_W-1:0]  id_c;
    logic               miso_bit;
    logic               sample_c;

`ifdef SPI_MASTER_MISO_SYNC_EN
    logic miso_meta;
    logic miso_sync;

    // Two-flop synchronizer for the asynchronous slave data line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
        end else begin
            miso_meta <= miso;
            miso_sync <= miso_meta;
        end
    end

    assign miso_bit = miso_sync;
    // Two edges after sclk rose, miso_sync holds the value present at the rise
    assign sample_c = (state == S_SHIFT) && sclk && (half_cnt == CNT_W'(1));
`else
    assign miso_bit = miso;
    // Sample on the same edge that drives sclk high
    assign sample_c = (state == S_SHIFT) && !sclk && (half_cnt == HALF_LAST);
`endif

    assign id_c = rw ? SLAVE_IDR : SLAVE_IDW;

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state, counter, shift and output-next logic
    always_comb begin
        state_d = state;
        half_d  = half_cnt;
        bit_d   = bit_cnt;
        sreg_d  = sreg;
        rx_d    = rx;
        rw_d    = rw_q;
        busy_d  = busy;
        done_d  = 1'b0;
        rdata_d = rdata;
        ss_d    = ss;
        sclk_d  = sclk;
        mosi_d  = mosi;

        if (sample_c && (bit_cnt >= RX_FIRST)) begin
            rx_d = {rx[BYTE_W-2:0], miso_bit};
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                    half_d  = '0;
                    bit_d   = '0;
                    rw_d    = rw;
                    rx_d    = '0;
                    sreg_d  = {id_c, addr, rw ? 8'h00 : wdata};
                    busy_d  = 1'b1;
                    ss_d    = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = id_c[BYTE_W-1];
                end
            end

            S_SETUP: begin
                if (half_cnt == HALF_LAST) begin
                    state_d = S_SHIFT;
                    half_d  = '0;
                end else begin
                    half_d = half_cnt + CNT_W'(1);
                end
            end

            S_SHIFT: begin
                if (half_cnt != HALF_LAST) begin
                    half_d = half_cnt + CNT_W'(1);
                end else begin
                    half_d = '0;
                    if (!sclk) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state_d = S_HOLD;
                        end else begin
                            bit_d  = bit_cnt + BIT_W'(1);
                            // Rotate so the next bit sits at the top
                            sreg_d = {sreg[SHIFT_W-2:0], sreg[SHIFT_W-1]};
                            mosi_d = sreg[SHIFT_W-2];
                        end
                    end
                end
            end

            S_HOLD: begin
                if (half_cnt == HALF_LAST) begin
                    state_d = S_GAP;
                    half_d  = '0;
                    ss_d    = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    if (rw_q) begin
                        rdata_d = rx;
                    end
                end else begin
                    half_d = half_cnt + CNT_W'(1);
                end
            end

            S_GAP: begin
                if (half_cnt == GAP_LAST) begin
                    state_d = S_IDLE;
                    half_d  = '0;
                    busy_d  = 1'b0;
                end else begin
                    half_d = half_cnt + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                half_d  = '0;
                bit_d   = '0;
                busy_d  = 1'b0;
                ss_d    = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            half_cnt <= '0;
            bit_cnt  <= '0;
            sreg     <= '0;
            rx       <= '0;
            rw_q     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdata    <= 8'h00;
            ss       <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
        end else begin
            half_cnt <= half_d;
            bit_cnt  <= bit_d;
            sreg     <= sreg_d;
            rx       <= rx_d;
            rw_q     <= rw_d;
            busy     <= busy_d;
            done     <= done_d;
            rdata    <= rdata_d;
            ss       <= ss_d;
            sclk     <= sclk_d;
            mosi     <= mosi_d;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: randomized and directed register
// transactions against a behavioural register-slave model, with a
// scoreboard checked by a monitor on every done pulse.
module tb_spi_master;

    localparam int CD  = 8;
    localparam int GAP = 8;
    localparam logic [7:0] IDW = 8'hFF;
    localparam logic [7:0] IDR = 8'h00;
    localparam int TXN_LEN = 50 * CD + GAP + 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       ss;
    logic       sclk;
    logic       mosi;
    logic       miso;

    spi_master #(
        .CLK_DIV  (CD),
        .SS_GAP   (GAP),
        .SLAVE_IDW(IDW),
        .SLAVE_IDR(IDR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .rw   (rw),
        .addr (addr),
        .wdata(wdata),
        .busy (busy),
        .done (done),
        .rdata(rdata),
        .ss   (ss),
        .sclk (sclk),
        .mosi (mosi),
        .miso (miso)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          acc;
        logic [23:0] stream;
        logic [7:0]  rdata;
    } exp_t;

    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    int         exp_done = 0;
    int         done_cnt = 0;
    exp_t       sb[$];
    logic [7:0] ref_mem[256];
    logic [7:0] model_rdata;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural register slave ----------------
    logic [7:0]  slave_mem[32];
    logic [23:0] s_shift;
    int          s_bits;
    logic        s_reading;
    logic [7:0]  s_rd;
    logic        s_prev_ss = 1'b1;
    logic        s_prev_sclk = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            s_bits    = 0;
            s_reading = 1'b0;
            miso      = 1'b0;
        end else begin
            if (s_prev_ss && !ss) begin
                s_bits    = 0;
                s_shift   = '0;
                s_reading = 1'b0;
                miso      = 1'b0;
            end
            if (!ss && !s_prev_sclk && sclk) begin
                s_shift = {s_shift[22:0], mosi};
                s_bits++;
            end
            if (!ss && s_prev_sclk && !sclk) begin
                if (s_bits == 16 && s_shift[15:8] == IDR) begin
                    s_reading = 1'b1;
                    s_rd      = (s_shift[7:0] < 8'h20) ? slave_mem[s_shift[4:0]] : 8'h00;
                end
                if (s_reading && s_bits >= 16 && s_bits < 24) begin
                    miso = s_rd[7];
                    s_rd = {s_rd[6:0], 1'b0};
                end else begin
                    miso = 1'b0;
                end
            end
            if (!s_prev_ss && ss) begin
                if (s_bits == 24 && s_shift[23:16] == IDW && s_shift[15:8] < 8'h20)
                    slave_mem[s_shift[12:8]] = s_shift[7:0];
                miso = 1'b0;
            end
        end
        s_prev_ss   = ss;
        s_prev_sclk = sclk;
    end

    // ---------------- monitor / scoreboard checker ----------------
    logic m_prev_ss = 1'b1;
    logic m_prev_sclk = 1'b0;
    logic m_prev_busy = 1'b0;
    int   m_rises = 0;
    int   m_last_acc = 0;
    bit   m_have_last = 1'b0;
    exp_t m_e;

    always @(negedge clock) begin
        if (reset) begin
            m_prev_ss   = 1'b1;
            m_prev_sclk = 1'b0;
            m_prev_busy = 1'b0;
            m_rises     = 0;
            m_have_last = 1'b0;
        end else begin
            if (m_prev_ss && !ss) begin
                m_rises = 0;
                if (sb.size() == 0) check("ss_fall_unexpected", 32'(cyc), 32'hFFFF_FFFF);
                else check("ss_fall_cycle", 32'(cyc), 32'(sb[0].acc + 1));
            end
            if (!m_prev_sclk && sclk) begin
                m_rises++;
                if (m_rises == 1 && sb.size() > 0)
                    check("first_sclk_rise_cycle", 32'(cyc), 32'(sb[0].acc + 1 + 2 * CD));
            end
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("done_unexpected", 32'(cyc), 32'hFFFF_FFFF);
                end else begin
                    m_e = sb.pop_front();
                    check("done_cycle", 32'(cyc), 32'(m_e.acc + 1 + 50 * CD));
                    check("ss_high_at_done", 32'(ss), 32'd1);
                    check("sclk_rises", 32'(m_rises), 32'd24);
                    check("mosi_stream", 32'(s_shift), 32'(m_e.stream));
                    check("rdata", 32'(rdata), 32'(m_e.rdata));
                    m_last_acc  = m_e.acc;
                    m_have_last = 1'b1;
                end
            end
            // ss stays high for the GAP cycles plus the IDLE cycle that accepts the next start
            if (m_prev_busy && !busy && m_have_last)
                check("busy_fall_cycle", 32'(cyc), 32'(m_last_acc + TXN_LEN));
            m_prev_ss   = ss;
            m_prev_sclk = sclk;
            m_prev_busy = busy;
        end
    end

    // ---------------- stimulus and reference model ----------------
    task automatic push_exp(input logic r, input logic [7:0] a, input logic [7:0] d, input int acc);
        exp_t e;
        e.acc    = acc;
        e.stream = {r ? IDR : IDW, a, r ? 8'h00 : d};
        if (r) model_rdata = (a < 8'h20) ? ref_mem[a] : 8'h00;
        else if (a < 8'h20) ref_mem[a] = d;
        e.rdata = model_rdata;
        sb.push_back(e);
        exp_done++;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (busy && n < 4 * TXN_LEN) begin
            @(negedge clock);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_txn(input logic r, input logic [7:0] a, input logic [7:0] d);
        wait_idle();
        rw    = r;
        addr  = a;
        wdata = d;
        start = 1'b1;
        push_exp(r, a, d, cyc);
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;
        logic       r;
        logic [7:0] a;
        logic [7:0] d;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 32; i++) slave_mem[i] = 8'h00;
        model_rdata = 8'h00;
        reset = 1'b1;
        start = 1'b0;
        rw    = 1'b0;
        addr  = 8'h00;
        wdata = 8'h00;
        miso  = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_ss", 32'(ss), 32'd1);
        check("reset_sclk", 32'(sclk), 32'd0);
        check("reset_mosi", 32'(mosi), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;

        do_txn(1'b0, 8'h10, 8'hA5);
        do_txn(1'b0, 8'h11, 8'h3C);
        do_txn(1'b0, 8'h12, 8'hC3);
        do_txn(1'b0, 8'h13, 8'h01);
        do_txn(1'b1, 8'h11, 8'h00);
        do_txn(1'b1, 8'h12, 8'h00);
        do_txn(1'b1, 8'h13, 8'h00);
        do_txn(1'b1, 8'h20, 8'h00);

        // start pulse at cycle 50 of an active write must be ignored
        do_txn(1'b0, 8'h15, 8'h96);
        repeat (49) @(negedge clock);
        rw    = 1'b1;
        addr  = 8'h11;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;

        // start held high: transactions run back to back
        wait_idle();
        acc = cyc;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                acc += TXN_LEN;
                while (cyc < acc) @(negedge clock);
            end
            r = (k != 0);
            a = (k == 2) ? 8'h11 : 8'h14;
            d = 8'h5A;
            rw    = r;
            addr  = a;
            wdata = d;
            start = 1'b1;
            push_exp(r, a, d, acc);
        end
        @(negedge clock);
        start = 1'b0;

        // reset 200 cycles into a read
        do_txn(1'b1, 8'h12, 8'h00);
        repeat (199) @(negedge clock);
        #2;
        reset = 1'b1;
        sb.delete();
        exp_done--;
        model_rdata = 8'h00;
        #1;
        check("midreset_ss", 32'(ss), 32'd1);
        check("midreset_sclk", 32'(sclk), 32'd0);
        check("midreset_mosi", 32'(mosi), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_rdata", 32'(rdata), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        do_txn(1'b0, 8'h13, 8'h77);
        do_txn(1'b1, 8'h13, 8'h00);

        // randomized traffic, occasionally to unmapped addresses
        for (int i = 0; i < 12; i++) begin
            r = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 63 : 31));
            d = 8'($urandom);
            wait_idle();
            repeat ($urandom_range(0, 20)) @(negedge clock);
            do_txn(r, a, d);
        end

        wait_idle();
        n = 0;
        while (sb.size() != 0 && n < 2 * TXN_LEN) begin
            @(negedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'(exp_done));
        for (int i = 0; i < 32; i++) check($sformatf("slave_reg_%0h", i), 32'(slave_mem[i]), 32'(ref_mem[i]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
